// File: rtl/psum_rmw_ctrl.sv
// rtl/psum_rmw_ctrl.sv - PSUM SRAM read-modify-write sequencer between OFIFO and SFP lanes
// Optional stall counter output enabled by `define PSUM_RMW_STALL_CNT_EN
module psum_rmw_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [cnt_bw-1:0]        num_rows,
  output logic                     busy,
  output logic                     done,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [col*psum_bw-1:0]   mem_d,
  input  logic [col*psum_bw-1:0]   mem_q,
  output logic [col*psum_bw-1:0]   sfp_psum,
  output logic [col*psum_bw-1:0]   sfp_ofifo,
  output logic                     sfp_accum,
  output logic                     sfp_passthrough,
  input  logic [col*psum_bw-1:0]   sfp_result
`ifdef PSUM_RMW_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int dw = col * psum_bw;
  localparam logic [1:0] m_pass = 2'b00;
  localparam logic [1:0] m_acc  = 2'b01;
  localparam logic [1:0] m_relu = 2'b10;

  typedef enum logic [1:0] {s_idle, s_rd, s_wr, s_done} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          mode_q;
  logic [addr_bw-1:0]  base_q;
  logic [cnt_bw-1:0]   num_q;
  logic [cnt_bw-1:0]   cnt;
  logic [dw-1:0]       ofifo_q;

  logic [1:0]          mode_eff;
  logic                accept;
  logic                stall;
  logic                rd_fire;
  logic                wr_fire;
  logic [cnt_bw-1:0]   cnt_inc;
  logic                last_row;
  logic [addr_bw-1:0]  row_addr;

  // Reserved mode 11 behaves as passthrough.
  assign mode_eff = (mode == 2'b11) ? m_pass : mode;
  assign accept   = (state == s_idle) && start;
  assign stall    = !ofifo_valid &&
                    (((state == s_rd) && (mode_q == m_acc)) ||
                     ((state == s_wr) && (mode_q == m_pass)));
  assign rd_fire  = (state == s_rd) && !stall;
  assign wr_fire  = (state == s_wr) && !stall;
  assign cnt_inc  = cnt + cnt_bw'(1);
  assign last_row = (cnt_inc == num_q);
  assign row_addr = base_q + addr_bw'(cnt);
  assign sfp_psum = mem_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= s_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= m_pass;
      base_q  <= '0;
      num_q   <= '0;
      cnt     <= '0;
      ofifo_q <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode_eff;
        base_q <= base_addr;
        num_q  <= num_rows;
        cnt    <= '0;
      end else if (wr_fire) begin
        cnt <= cnt_inc;
      end
      if (rd_fire && (mode_q == m_acc)) begin
        ofifo_q <= ofifo_out;
      end
    end
  end

`ifdef PSUM_RMW_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      s_idle: begin
        if (start) begin
          if (num_rows == '0) begin
            state_nxt = s_done;
          end else if (mode_eff == m_pass) begin
            state_nxt = s_wr;
          end else begin
            state_nxt = s_rd;
          end
        end
      end
      s_rd: begin
        if (!stall) begin
          state_nxt = s_wr;
        end
      end
      s_wr: begin
        if (!stall) begin
          if (last_row) begin
            state_nxt = s_done;
          end else if (mode_q != m_pass) begin
            state_nxt = s_rd;
          end
        end
      end
      s_done: state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    ofifo_rd        = 1'b0;
    mem_cen         = 1'b1;
    mem_wen         = 1'b1;
    mem_addr        = '0;
    mem_d           = '0;
    sfp_accum       = 1'b0;
    sfp_passthrough = 1'b0;
    sfp_ofifo       = ofifo_q;
    case (state)
      s_rd: begin
        busy      = 1'b1;
        sfp_accum = (mode_q == m_acc);
        if (!stall) begin
          mem_cen  = 1'b0;
          mem_addr = row_addr;
          ofifo_rd = (mode_q == m_acc);
        end
      end
      s_wr: begin
        busy            = 1'b1;
        sfp_accum       = (mode_q == m_acc);
        sfp_passthrough = (mode_q == m_pass);
        // Passthrough pops and writes in one cycle, so the SFP sees the live head row.
        if (mode_q == m_pass) begin
          sfp_ofifo = ofifo_out;
        end
        if (!stall) begin
          mem_cen  = 1'b0;
          mem_wen  = 1'b0;
          mem_addr = row_addr;
          mem_d    = sfp_result;
          ofifo_rd = (mode_q == m_pass);
        end
      end
      s_done: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/psum_rmw_ctrl.md
Name: psum_rmw_ctrl

Overview:
- Sequencer that moves rows from the output FIFO into PSUM SRAM through the SFP stage.
- Issues the SRAM read, pops the OFIFO, and drives the SFP control and data inputs. It then writes the SFP result back to the same SRAM address.
- Sits between the OFIFO/PSUM SRAM and the SFP lanes. It owns the PSUM SRAM port during a job.
- Supports three modes: passthrough store, accumulate, and in-place ReLU.

Parameters:
- col, 8, number of SFP lanes (array columns) per row
- psum_bw, 16, partial-sum width per lane
- addr_bw, 11, PSUM SRAM address width
- cnt_bw, 11, row-count width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk edge, 0 = reset
- start  input  1  one-cycle job request; sampled only in IDLE
- mode  input  2  latched at start: 00 passthrough, 01 accumulate, 10 ReLU, 11 reserved (treated as 00)
- base_addr  input  addr_bw  first SRAM row address, latched at start
- num_rows  input  cnt_bw  rows to process, latched at start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the job completes
- ofifo_valid  input  1  OFIFO holds at least one full row
- ofifo_rd  output  1  pop strobe; data is valid on ofifo_out in the same cycle
- ofifo_out  input  col*psum_bw  OFIFO head row
- mem_cen  output  1  SRAM chip enable, active-low
- mem_wen  output  1  SRAM write enable, active-low (1 = read)
- mem_addr  output  addr_bw  SRAM address
- mem_d  output  col*psum_bw  SRAM write data
- mem_q  input  col*psum_bw  SRAM read data, valid one cycle after a read
- sfp_psum  output  col*psum_bw  to SFP psum_in lanes (= mem_q)
- sfp_ofifo  output  col*psum_bw  to SFP ofifo_in lanes (registered OFIFO row)
- sfp_accum  output  1  to SFP accum on all lanes
- sfp_passthrough  output  1  to SFP passthrough on all lanes
- sfp_result  input  col*psum_bw  SFP outputs, concatenated

Behaviour:
- Reset values (reset=0 at edge):
  - state=IDLE; busy=0, done=0, ofifo_rd=0.
  - mem_cen=1, mem_wen=1; mem_addr=0, mem_d=0.
  - sfp_ofifo register=0; sfp_accum=0, sfp_passthrough=0; row counter=0.
- Reset mid-job aborts immediately. No write completes after the reset edge, and no done pulse is issued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 latches mode, base_addr and num_rows.
  - num_rows=0 -> DONE.
  - Passthrough mode -> WR.
  - Otherwise -> RD.
- RD (accumulate/ReLU):
  - Accumulate: the state stalls with mem_cen=1 and no pop while ofifo_valid=0.
  - Accumulate, when able: mem_cen=0, mem_wen=1, mem_addr=base+cnt. ofifo_rd=1 in the same cycle, and ofifo_out is registered into sfp_ofifo. -> WR.
  - ReLU: issues the read unconditionally, never pops. -> WR.
- WR:
  - Passthrough needs ofifo_valid. It stalls in WR with mem_cen=1 until the OFIFO has a row, then pops it that cycle, and mem_d = ofifo_out via the SFP passthrough.
  - All modes write with mem_cen=0, mem_wen=0, mem_addr=base+cnt, mem_d=sfp_result.
  - Accumulate/ReLU: sfp_psum=mem_q, available in this cycle.
  - After the write, cnt increments. If cnt+1==num_rows -> DONE. Else -> RD (accumulate/ReLU) or stay in WR (passthrough).
- DONE: done=1 for exactly one cycle, busy drops -> IDLE.
- SFP controls follow the latched mode:
  - accumulate: accum=1, passthrough=0
  - ReLU: accum=0, passthrough=0
  - passthrough: passthrough=1
  - Controls are 0 in IDLE.
- Throughput and latency:
  - 2 cycles/row for accumulate/ReLU; 1 cycle/row for passthrough (excluding stalls).
  - start to done = 2N+1 cycles unstalled (N+1 for passthrough).
- Address: base+cnt wraps modulo 2^addr_bw.
- The SRAM is never read and written in the same cycle. A single port is assumed.
- start while busy is ignored. start and done may coincide only as done then a next-cycle start.

Optional Feature:
- PSUM_RMW_STALL_CNT_EN defined:
  - adds output stall_cycles [31:0].
  - Counts cycles spent stalled on ofifo_valid=0 during the current job.
  - Clears on accepted start; holds after done; reset 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Passthrough: base=0x10, N=3, OFIFO rows A,B,C always valid -> writes at 0x10/0x11/0x12 in consecutive cycles, data A,B,C. done at cycle 4 after start.
- Accumulate: SRAM[5]=lanes all 0x0003, OFIFO row all 0x0004, N=1 -> one read at addr 5, then write 0x0007 per lane. One pop, done 3 cycles after start.
- ReLU: SRAM[7] lanes {0x8001, 0x0005,...} -> written {0x0000, 0x0005,...}. ofifo_rd never asserted.
- Stall and wrap:
  - Accumulate with base=0x7FF, N=2, ofifo_valid low for 4 cycles in the 2nd RD.
  - Required: addresses 0x7FF then 0x000, mem_cen=1 during the stall.
  - Required: stall_cycles=4 when the macro is defined.
- Edge control: N=0 -> done the cycle after start with no SRAM access. A start while busy is ignored.
- Reset abort: reset=0 asserted in a WR cycle mid-job -> the next cycle shows all reset values and no write. A new start then runs normally.
